// File: rtl/mem_port_arbiter.sv
// Arbitrates one single-ported memory between instruction fetch and data access.
// Data wins by default; a streak counter forces a fetch grant, and a watchdog aborts stuck accesses.
//
// state | meaning
// IDLE  | no command outstanding; grant decision and m_req strobe happen here
// WAIT  | command issued, waiting for m_valid or watchdog expiry
// RESP  | one-cycle ack (and err on abort) to the recorded grantee
module mem_port_arbiter #(
   parameter int AW           = 32,
   parameter int DW           = 32,
   parameter int MAX_D_STREAK = 4,
   parameter int TIMEOUT      = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_req,
   input  logic [AW-1:0]   i_addr,
   output logic            i_ack,
   output logic [DW-1:0]   i_rdata,
   input  logic            d_req,
   input  logic            d_we,
   input  logic [DW/8-1:0] d_be,
   input  logic [AW-1:0]   d_addr,
   input  logic [DW-1:0]   d_wdata,
   output logic            d_ack,
   output logic [DW-1:0]   d_rdata,
   output logic            m_req,
   output logic            m_we,
   output logic [DW/8-1:0] m_be,
   output logic [AW-1:0]   m_addr,
   output logic [DW-1:0]   m_wdata,
   input  logic            m_valid,
   input  logic [DW-1:0]   m_rdata,
   output logic            err
);

   localparam int BW = DW / 8;
   localparam int SW = $clog2(MAX_D_STREAK + 1);
   localparam int WW = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t        state, state_nxt;
   logic          gnt_d, gnt_i;
   logic          sel_d, sel_we, timed_out;
   logic [SW-1:0] d_streak;
   logic [WW-1:0] wdog;
   logic          wdog_exp;

   assign wdog_exp = (wdog == WW'(TIMEOUT - 1));

   // Grants are suppressed during reset so no command strobe leaks out.
   always_comb begin
      gnt_d = 1'b0;
      gnt_i = 1'b0;
      if (!rst && state == IDLE) begin
         gnt_d = d_req && !(i_req && d_streak == SW'(MAX_D_STREAK));
         gnt_i = !gnt_d && i_req;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (gnt_d || gnt_i) state_nxt = WAIT;
         WAIT:    if (m_valid || wdog_exp) state_nxt = RESP;
         RESP:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      m_req   = gnt_d || gnt_i;
      m_we    = gnt_d && d_we;
      m_be    = '0;
      m_addr  = '0;
      m_wdata = '0;
      if (gnt_d) begin
         m_be    = d_be;
         m_addr  = d_addr;
         m_wdata = d_wdata;
      end else if (gnt_i) begin
         m_be    = {BW{1'b1}};
         m_addr  = i_addr;
      end
      i_ack = !rst && state == RESP && !sel_d;
      d_ack = !rst && state == RESP && sel_d;
      err   = !rst && state == RESP && timed_out;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         d_streak  <= '0;
         wdog      <= '0;
         sel_d     <= 1'b0;
         sel_we    <= 1'b0;
         timed_out <= 1'b0;
         i_rdata   <= '0;
         d_rdata   <= '0;
      end else begin
         case (state)
            IDLE: begin
               if (gnt_d || gnt_i) begin
                  sel_d     <= gnt_d;
                  sel_we    <= gnt_d && d_we;
                  wdog      <= '0;
                  timed_out <= 1'b0;
               end
               if (gnt_d && i_req) begin
                  if (d_streak != SW'(MAX_D_STREAK)) d_streak <= d_streak + SW'(1);
               end else if (gnt_d || gnt_i) begin
                  d_streak <= '0;
               end
            end
            WAIT: begin
               // A response arriving on the expiry cycle still completes normally.
               if (m_valid) begin
                  if (sel_d) d_rdata <= sel_we ? '0 : m_rdata;
                  else       i_rdata <= m_rdata;
               end else if (wdog_exp) begin
                  timed_out <= 1'b1;
                  if (sel_d) d_rdata <= '0;
                  else       i_rdata <= '0;
               end else begin
                  wdog <= wdog + WW'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: vector table of single accesses plus
// sequences for reset, conflict, starvation and reset-during-wait.
module tb_mem_port_arbiter;

   logic        clk, rst;
   logic        i_req, i_ack;
   logic [31:0] i_addr, i_rdata;
   logic        d_req, d_we, d_ack;
   logic [3:0]  d_be, m_be;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic        m_req, m_we, m_valid, err;
   logic [31:0] m_addr, m_wdata, m_rdata;

   mem_port_arbiter dut (
      .clk(clk), .rst(rst),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .m_req(m_req), .m_we(m_we), .m_be(m_be), .m_addr(m_addr), .m_wdata(m_wdata),
      .m_valid(m_valid), .m_rdata(m_rdata), .err(err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int pass_cnt = 0;
   int total_cnt = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h, expected %h", nm, act, exp);
   endtask

   function automatic logic [31:0] mem_fn(input logic [31:0] a);
      if (a == 32'h10)  return 32'h00500093;
      if (a == 32'h200) return 32'h12345678;
      return {a[15:0], 16'hC0DE};
   endfunction

   // memory responder: m_valid auto_lat cycles after m_req (0 = never)
   int          auto_lat = 1;
   logic        pend;
   int          cnt;
   logic [31:0] paddr;
   initial begin
      pend = 1'b0; cnt = 0; paddr = '0;
      m_valid = 1'b0; m_rdata = '0;
      forever begin
         @(negedge clk);
         if (m_req) begin
            pend = 1'b1; cnt = 0; paddr = m_addr;
         end
         @(posedge clk);
         #1;
         if (pend) cnt++;
         if (pend && auto_lat != 0 && cnt == auto_lat) begin
            m_valid = 1'b1;
            m_rdata = mem_fn(paddr);
            pend    = 1'b0;
         end else begin
            m_valid = 1'b0;
            m_rdata = 32'hDEAD0000;
         end
      end
   end

   int          mreq_cyc[$], err_cyc[$], iack_cyc[$], dack_cyc[$];
   logic [31:0] mreq_addr[$], mreq_wd[$], iack_data[$], dack_data[$], iack_other[$], dack_other[$];
   logic        mreq_we[$];
   logic [3:0]  mreq_be[$];
   logic        d_hold = 1'b0;

   task automatic clear_logs();
      mreq_cyc.delete(); err_cyc.delete(); iack_cyc.delete(); dack_cyc.delete();
      mreq_addr.delete(); mreq_wd.delete(); mreq_we.delete(); mreq_be.delete();
      iack_data.delete(); dack_data.delete(); iack_other.delete(); dack_other.delete();
   endtask

   // Called at posedge+1 of cycle 0; returns at posedge+1 of cycle n.
   task automatic run_cycles(input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         if (m_req) begin
            mreq_cyc.push_back(c); mreq_addr.push_back(m_addr);
            mreq_we.push_back(m_we); mreq_be.push_back(m_be); mreq_wd.push_back(m_wdata);
         end
         if (err) err_cyc.push_back(c);
         if (i_ack) begin
            iack_cyc.push_back(c); iack_data.push_back(i_rdata); iack_other.push_back(d_rdata);
            i_req = 1'b0;
         end
         if (d_ack) begin
            dack_cyc.push_back(c); dack_data.push_back(d_rdata); dack_other.push_back(i_rdata);
            if (d_hold) d_addr = d_addr + 32'd4;
            else        d_req = 1'b0;
         end
         @(posedge clk);
         #1;
      end
   endtask

   logic [31:0] exp_i_rd = '0;
   logic [31:0] exp_d_rd = '0;

   task automatic do_reset();
      rst = 1'b1; i_req = 1'b0; d_req = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      exp_i_rd = '0; exp_d_rd = '0;
   endtask

   typedef struct {
      logic        is_d;
      logic        we;
      logic [3:0]  be;
      logic [31:0] addr;
      logic [31:0] wdata;
      int          lat;
      int          exp_ack;
      logic [31:0] exp_rdata;
      logic        exp_err;
   } vec_t;

   task automatic run_vec(input vec_t v);
      clear_logs();
      auto_lat = v.lat;
      if (v.is_d) begin
         d_req = 1'b1; d_we = v.we; d_be = v.be; d_addr = v.addr; d_wdata = v.wdata;
      end else begin
         i_req = 1'b1; i_addr = v.addr;
      end
      run_cycles(20);
      d_we = 1'b0; d_be = '0; d_wdata = '0;
      chk("mreq_count", mreq_cyc.size(), 1);
      if (mreq_cyc.size() > 0) begin
         chk("mreq_cycle", mreq_cyc[0], 0);
         chk("m_addr", mreq_addr[0], v.addr);
         chk("m_we", mreq_we[0], v.is_d ? v.we : 1'b0);
         chk("m_be", mreq_be[0], v.is_d ? v.be : 4'hF);
         chk("m_wdata", mreq_wd[0], v.is_d ? v.wdata : 32'h0);
      end
      if (v.is_d) begin
         chk("d_ack_count", dack_cyc.size(), 1);
         chk("stray_i_ack", iack_cyc.size(), 0);
         if (dack_cyc.size() > 0) begin
            chk("d_ack_cycle", dack_cyc[0], v.exp_ack);
            chk("d_rdata", dack_data[0], v.exp_rdata);
            chk("i_rdata_kept", dack_other[0], exp_i_rd);
         end
         exp_d_rd = v.exp_rdata;
      end else begin
         chk("i_ack_count", iack_cyc.size(), 1);
         chk("stray_d_ack", dack_cyc.size(), 0);
         if (iack_cyc.size() > 0) begin
            chk("i_ack_cycle", iack_cyc[0], v.exp_ack);
            chk("i_rdata", iack_data[0], v.exp_rdata);
            chk("d_rdata_kept", iack_other[0], exp_d_rd);
         end
         exp_i_rd = v.exp_rdata;
      end
      chk("err_count", err_cyc.size(), v.exp_err);
      if (err_cyc.size() > 0) chk("err_cycle", err_cyc[0], v.exp_ack);
   endtask

   vec_t        vecs[7];
   logic [31:0] starve_addr[7];
   vec_t        final_fetch;

   initial begin
      vecs[0] = '{1'b0, 1'b0, 4'hF, 32'h10,  32'h0,      1,  2, 32'h00500093, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 4'hF, 32'h200, 32'h0,      3,  4, 32'h12345678, 1'b0};
      vecs[2] = '{1'b1, 1'b1, 4'h3, 32'h300, 32'h0000A5A5, 2, 3, 32'h0,        1'b0};
      vecs[3] = '{1'b0, 1'b0, 4'hF, 32'h14,  32'h0,      5,  6, 32'h0014C0DE, 1'b0};
      vecs[4] = '{1'b1, 1'b0, 4'hF, 32'h400, 32'h0,      0, 16, 32'h0,        1'b1};
      vecs[5] = '{1'b0, 1'b0, 4'hF, 32'h20,  32'h0,     15, 16, 32'h0020C0DE, 1'b0};
      vecs[6] = '{1'b1, 1'b0, 4'hF, 32'h500, 32'h0,     14, 15, 32'h0500C0DE, 1'b0};
      starve_addr = '{32'h300, 32'h304, 32'h308, 32'h30C, 32'h40, 32'h310, 32'h314};
      final_fetch = '{1'b0, 1'b0, 4'hF, 32'h10, 32'h0, 1, 2, 32'h00500093, 1'b0};

      rst = 1'b1; i_req = 1'b1; d_req = 1'b1; d_we = 1'b0; d_be = 4'hF;
      i_addr = 32'h10; d_addr = 32'h200; d_wdata = 32'h0;
      auto_lat = 1;

      // reset holds every output low even with both requests raised
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk("reset_outputs_zero",
             {31'b0, |{m_req, m_we, m_be, m_addr, m_wdata, i_ack, d_ack, err, i_rdata, d_rdata}}, 32'h0);
      end
      @(posedge clk);
      #1;
      rst = 1'b0; i_req = 1'b0; d_req = 1'b0;
      clear_logs();
      run_cycles(4);
      chk("idle_no_mreq", mreq_cyc.size(), 0);

      foreach (vecs[k]) run_vec(vecs[k]);

      // conflict: data first, fetch issued right after the data ack
      clear_logs();
      auto_lat = 1;
      i_req = 1'b1; i_addr = 32'h10;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h200;
      run_cycles(10);
      chk("conf_mreq_count", mreq_cyc.size(), 2);
      if (mreq_cyc.size() == 2) begin
         chk("conf_first_addr", mreq_addr[0], 32'h200);
         chk("conf_second_cycle", mreq_cyc[1], 3);
         chk("conf_second_addr", mreq_addr[1], 32'h10);
      end
      chk("conf_d_ack_count", dack_cyc.size(), 1);
      chk("conf_i_ack_count", iack_cyc.size(), 1);
      if (dack_cyc.size() > 0) begin
         chk("conf_d_ack_cycle", dack_cyc[0], 2);
         chk("conf_d_rdata", dack_data[0], 32'h12345678);
      end
      if (iack_cyc.size() > 0) begin
         chk("conf_i_ack_cycle", iack_cyc[0], 5);
         chk("conf_i_rdata", iack_data[0], 32'h00500093);
      end

      // starvation: four data grants, one fetch, then data resumes
      do_reset();
      clear_logs();
      d_hold = 1'b1;
      d_req = 1'b1; d_addr = 32'h300;
      i_req = 1'b1; i_addr = 32'h40;
      run_cycles(21);
      d_hold = 1'b0; d_req = 1'b0; i_req = 1'b0;
      chk("starve_grant_count", mreq_cyc.size(), 7);
      if (mreq_cyc.size() == 7) begin
         for (int k = 0; k < 7; k++) begin
            chk("starve_grant_cycle", mreq_cyc[k], 3 * k);
            chk("starve_grant_addr", mreq_addr[k], starve_addr[k]);
         end
      end
      chk("starve_i_ack_count", iack_cyc.size(), 1);
      if (iack_cyc.size() > 0) chk("starve_i_ack_cycle", iack_cyc[0], 14);
      chk("starve_d_ack_count", dack_cyc.size(), 6);
      repeat (3) @(posedge clk);
      #1;

      // reset while waiting, then a late m_valid must be ignored
      do_reset();
      clear_logs();
      auto_lat = 6;
      d_req = 1'b1; d_we = 1'b0; d_be = 4'hF; d_addr = 32'h600;
      run_cycles(3);
      chk("rstw_issued", mreq_cyc.size(), 1);
      clear_logs();
      rst = 1'b1; d_req = 1'b0;
      run_cycles(1);
      rst = 1'b0;
      run_cycles(10);
      chk("rstw_no_d_ack", dack_cyc.size(), 0);
      chk("rstw_no_err", err_cyc.size(), 0);
      chk("rstw_no_mreq", mreq_cyc.size(), 0);
      chk("rstw_d_rdata_cleared", d_rdata, 32'h0);
      exp_i_rd = '0; exp_d_rd = '0;

      run_vec(final_fetch);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL global_timeout: simulation did not finish, expected completion");
      $fatal(1);
   end

endmodule
